// File: rtl/pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// pipelined_control_unit
//
// Control unit for a five-stage MIPS pipeline. It decodes the ID-stage opcode
// into a control bundle and carries the bundle through three registered stages:
// ID/EX, EX/MEM and MEM/WB. The destination register is resolved at decode
// (rd, rt or LINK_REG) and travels with the bundle.
//
// Ports:
//   i_clock, i_reset            clock (rising edge), asynchronous active-low reset
//   i_valid                     ID stage holds a real instruction
//   i_instruction_opcode        ID opcode
//   i_rs, i_rt, i_rd            ID register fields
//   i_flush                     kill the ID instruction (taken branch/jump in EX)
//   o_stall                     combinational load-use stall request
//   o_ex_*                      EX-stage controls (ID/EX register)
//   o_mem_*                     MEM-stage controls (EX/MEM register)
//   o_wb_*                      WB-stage controls (MEM/WB register)
// -----------------------------------------------------------------------------
module pipelined_control_unit #(
    parameter int NB_ADDR           = 5,
    parameter int NB_OPCODE         = 6,
    parameter int NB_ALU_OP_SEL     = 2,
    parameter int NB_LOAD_STORE_SEL = 2,
    parameter int LINK_REG          = 31
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_valid,
    input  logic [NB_OPCODE-1:0]         i_instruction_opcode,
    input  logic [NB_ADDR-1:0]           i_rs,
    input  logic [NB_ADDR-1:0]           i_rt,
    input  logic [NB_ADDR-1:0]           i_rd,
    input  logic                         i_flush,
    output logic                         o_stall,
    output logic [NB_ALU_OP_SEL-1:0]     o_ex_alu_operation,
    output logic                         o_ex_alu_data_src,
    output logic                         o_ex_signed_operation,
    output logic                         o_ex_inmediate_operation,
    output logic                         o_ex_branch,
    output logic                         o_ex_jump,
    output logic                         o_ex_illegal,
    output logic                         o_mem_rd_enb,
    output logic                         o_mem_wr_enb,
    output logic [NB_LOAD_STORE_SEL-1:0] o_mem_load_store_sel,
    output logic                         o_wb_rf_wr_enb,
    output logic                         o_wb_rf_wr_data_src,
    output logic [NB_ADDR-1:0]           o_wb_rf_wr_addr,
    output logic                         o_wb_link
);

    // Control consumed in EX only.
    typedef struct packed {
        logic [NB_ALU_OP_SEL-1:0] alu_op;
        logic                     alu_src;
        logic                     signed_op;
        logic                     imm_op;
        logic                     branch;
        logic                     jump;
        logic                     illegal;
    } ex_ctrl_t;

    // Control consumed in MEM.
    typedef struct packed {
        logic                         rd;
        logic                         wr;
        logic [NB_LOAD_STORE_SEL-1:0] ls_sel;
    } mem_ctrl_t;

    // Control consumed in WB.
    typedef struct packed {
        logic               wr;
        logic               src;
        logic [NB_ADDR-1:0] addr;
        logic               link;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ex_mem_t;

    // Halfword accesses end in 01, byte accesses in 00; word and the rest use 00.
    function automatic logic [NB_LOAD_STORE_SEL-1:0] ls_size(input logic [NB_OPCODE-1:0] op);
        logic [NB_LOAD_STORE_SEL-1:0] sel;
        case (op[1:0])
            2'b01:   sel = 2'b10;
            2'b00:   sel = 2'b01;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

    ctrl_t    dec_s;
    ctrl_t    id_ex_next_s;
    logic     reads_rs_s;
    logic     reads_rt_s;
    logic     hazard_s;
    ctrl_t    id_ex_r;
    ex_mem_t  ex_mem_r;
    wb_ctrl_t mem_wb_r;

    // Opcode decode into a control bundle plus which source fields are read.
    always_comb begin
        dec_s      = '0;
        reads_rs_s = 1'b0;
        reads_rt_s = 1'b0;
        casez (i_instruction_opcode)
            6'b0000??: begin // R-type
                dec_s.wb.wr   = 1'b1;
                dec_s.wb.addr = i_rd;
                reads_rs_s    = 1'b1;
                reads_rt_s    = 1'b1;
            end
            6'b100???: begin // signed (1000??) and unsigned (1001??) loads
                dec_s.ex.alu_op  = 2'b01;
                dec_s.ex.alu_src = 1'b1;
                dec_s.mem.rd     = 1'b1;
                dec_s.mem.ls_sel = ls_size(i_instruction_opcode);
                dec_s.wb.wr      = 1'b1;
                dec_s.wb.src     = 1'b1;
                dec_s.wb.addr    = i_rt;
                reads_rs_s       = 1'b1;
            end
            6'b1010??: begin // stores
                dec_s.ex.alu_op    = 2'b01;
                dec_s.ex.alu_src   = 1'b1;
                dec_s.ex.signed_op = 1'b1;
                dec_s.mem.wr       = 1'b1;
                dec_s.mem.ls_sel   = ls_size(i_instruction_opcode);
                reads_rs_s         = 1'b1;
                reads_rt_s         = 1'b1;
            end
            6'b1011??: begin // branches
                dec_s.ex.alu_op = 2'b10;
                dec_s.ex.branch = 1'b1;
                reads_rs_s      = 1'b1;
                reads_rt_s      = 1'b1;
            end
            6'b111???: begin // ALU immediates
                dec_s.ex.alu_src = 1'b1;
                dec_s.ex.imm_op  = 1'b1;
                dec_s.wb.wr      = 1'b1;
                dec_s.wb.addr    = i_rt;
                reads_rs_s       = 1'b1;
            end
            6'b110010: begin // J
                dec_s.ex.jump = 1'b1;
            end
            6'b110001: begin // JR
                dec_s.ex.jump = 1'b1;
                reads_rs_s    = 1'b1;
            end
            6'b011001: begin // JAL
                dec_s.ex.jump = 1'b1;
                dec_s.wb.wr   = 1'b1;
                dec_s.wb.addr = NB_ADDR'(LINK_REG);
                dec_s.wb.link = 1'b1;
            end
            6'b011011: begin // JALR
                dec_s.ex.jump = 1'b1;
                dec_s.wb.wr   = 1'b1;
                dec_s.wb.addr = i_rd;
                dec_s.wb.link = 1'b1;
                reads_rs_s    = 1'b1;
            end
            default: begin
                dec_s.ex.illegal = 1'b1;
            end
        endcase
    end

    // Load-use detection against the load sitting in EX; flush masks the stall
    // because the ID instruction is being discarded anyway.
    always_comb begin
        hazard_s = 1'b0;
        if (i_valid && !i_flush && id_ex_r.mem.rd && (id_ex_r.wb.addr != '0)) begin
            hazard_s = (reads_rs_s && (i_rs == id_ex_r.wb.addr)) ||
                       (reads_rt_s && (i_rt == id_ex_r.wb.addr));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Bubble selection for the ID/EX input.
    always_comb begin
        id_ex_next_s = '0;
        if (!i_valid || i_flush || hazard_s) begin
            id_ex_next_s = '0;
        end else begin
            id_ex_next_s = dec_s;
        end
    end

    // Pipeline registers: ID/EX, EX/MEM, MEM/WB.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            id_ex_r  <= '0;
            ex_mem_r <= '0;
            mem_wb_r <= '0;
        end else begin
            id_ex_r      <= id_ex_next_s;
            ex_mem_r.mem <= id_ex_r.mem;
            ex_mem_r.wb  <= id_ex_r.wb;
            mem_wb_r     <= ex_mem_r.wb;
        end
    end

    assign o_stall                  = hazard_s;
    assign o_ex_alu_operation       = id_ex_r.ex.alu_op;
    assign o_ex_alu_data_src        = id_ex_r.ex.alu_src;
    assign o_ex_signed_operation    = id_ex_r.ex.signed_op;
    assign o_ex_inmediate_operation = id_ex_r.ex.imm_op;
    assign o_ex_branch              = id_ex_r.ex.branch;
    assign o_ex_jump                = id_ex_r.ex.jump;
    assign o_ex_illegal             = id_ex_r.ex.illegal;
    assign o_mem_rd_enb             = ex_mem_r.mem.rd;
    assign o_mem_wr_enb             = ex_mem_r.mem.wr;
    assign o_mem_load_store_sel     = ex_mem_r.mem.ls_sel;
    assign o_wb_rf_wr_enb           = mem_wb_r.wr;
    assign o_wb_rf_wr_data_src      = mem_wb_r.src;
    assign o_wb_rf_wr_addr          = mem_wb_r.addr;
    assign o_wb_link                = mem_wb_r.link;

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation MIPS control unit for the pipelined datapath.
- Decodes the ID-stage opcode into a control bundle and carries it through three registered stages: ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and emits a stall. On a flush from the branch/jump resolver it inserts bubbles.
- Adds link (JAL/JALR) handling, registered destination-address selection and illegal-opcode flagging.

Parameters:
- NB_ADDR, 5, register-file address width.
- NB_OPCODE, 6, opcode width.
- NB_ALU_OP_SEL, 2, ALU operation selector width.
- NB_LOAD_STORE_SEL, 2, load/store size selector width.
- LINK_REG, 31, destination register written by JAL.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  ID stage holds a real instruction.
- i_instruction_opcode  in  NB_OPCODE  ID opcode.
- i_rs  in  NB_ADDR  ID rs field.
- i_rt  in  NB_ADDR  ID rt field.
- i_rd  in  NB_ADDR  ID rd field.
- i_flush  in  1  taken branch/jump resolved in EX; kill the ID instruction.
- o_stall  out  1  combinational; hold PC and IF/ID this cycle.
- o_ex_alu_operation  out  NB_ALU_OP_SEL  00 R-type/immediate, 01 add, 10 sub/compare.
- o_ex_alu_data_src  out  1  0 = register file, 1 = immediate.
- o_ex_signed_operation  out  1  sign-extend the immediate.
- o_ex_inmediate_operation  out  1  ALU control uses the opcode instead of funct.
- o_ex_branch  out  1  BEQ/BNE in EX.
- o_ex_jump  out  1  J/JR/JAL/JALR in EX.
- o_ex_illegal  out  1  unknown opcode in EX.
- o_mem_rd_enb  out  1  data memory read.
- o_mem_wr_enb  out  1  data memory write.
- o_mem_load_store_sel  out  NB_LOAD_STORE_SEL  00 word, 01 byte, 10 half.
- o_wb_rf_wr_enb  out  1  register-file write enable.
- o_wb_rf_wr_data_src  out  1  0 = ALU/link value, 1 = memory.
- o_wb_rf_wr_addr  out  NB_ADDR  resolved destination register.
- o_wb_link  out  1  write PC+8 (JAL/JALR).

Behaviour:
- Reset: i_clock and i_reset (async, active-low). While i_reset=0, every stage register and every registered output is 0 immediately. Registers leave reset on the first rising edge after release.
- Decode (combinational, ID):
  - 0000?? R-type: write rd, reads rs and rt.
  - 1000?? signed load, 1001?? unsigned load: write rt from memory, alu add, imm, reads rs.
  - 1010?? store: mem write, alu add, imm, signed, reads rs and rt.
  - 111??? immediate: write rt, imm, inmediate_operation=1, reads rs.
  - 1011?? branch: branch=1, alu 10, reads rs and rt.
  - J 110010: jump, no write.
  - JR 110001: jump, no write, reads rs.
  - JAL 011001: jump, write LINK_REG, link=1.
  - JALR 011011: jump, write rd, link=1, reads rs.
  - Any other opcode: all-zero bundle with illegal=1.
- Size select: LH/LHU/SH give 10; LB/LBU/SB give 01; everything else gives 00.
- Latency: an ID instruction's control appears on o_ex_* 1 cycle later, o_mem_* 2 cycles later and o_wb_* 3 cycles later. The destination address is resolved at decode and carried down the pipe.
- Load-use hazard (o_stall=1) requires all of:
  - i_valid=1;
  - the EX stage holds a load (mem_rd_enb=1) with destination d != 0;
  - the ID instruction reads rs==d or rt==d (only fields actually read count).
- While o_stall=1, a bubble (all-zero bundle) enters ID/EX. EX/MEM and MEM/WB advance normally. o_stall drops the cycle after the load leaves EX.
- i_flush=1: a bubble enters ID/EX regardless of decode, and o_stall is forced to 0. Flush has priority over stall.
- i_valid=0: a bubble enters ID/EX; illegal=0.
- Bubble definition: every enable, branch, jump, link and illegal bit is 0, and every other field is 0.
- Destination register 0: a write enable is still propagated for it (the register file ignores writes to 0), but it never triggers a stall.
- Reset mid-operation: all stages clear at once; no partial bundle survives.

Test Plan:
- Reset: hold i_reset=0 with any inputs → all o_* = 0 and o_stall=0. After release, feed ADDI (111000, rt=4): o_ex_inmediate_operation=1 at +1 cycle; o_wb_rf_wr_enb=1 and o_wb_rf_wr_addr=4 at +3.
- Load-use hazard:
  - LW (100011, rt=5) then R-type with rs=5 → o_stall=1 for exactly 1 cycle, and o_ex_* is all zero the next cycle.
  - With rs=rt=6 instead → no stall.
- Flush priority: the same hazard pair with i_flush=1 in the stall cycle → o_stall=0 and the next EX bundle is a bubble.
- Link jumps:
  - JAL (011001) → o_ex_jump=1; then o_wb_link=1, o_wb_rf_wr_enb=1, o_wb_rf_wr_addr=31.
  - JALR with rd=9 → o_wb_rf_wr_addr=9.
  - J (110010) → o_wb_rf_wr_enb=0.
- Memory sizes: SH (101001) → o_mem_wr_enb=1, o_mem_load_store_sel=10. LBU (100100) → o_mem_rd_enb=1, sel=01. SW (101011) → sel=00.
- Illegal opcode: 010101 → o_ex_illegal=1 for one cycle; no memory or register-file enables downstream.
